// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result select, load type, byte lanes.
// Pure declarations, no logic.
// No flow control.
package wb_pkg;

    typedef enum logic [1:0] {
        MTR_ALU  = 2'd0,
        MTR_LOAD = 2'd1,
        MTR_PC4  = 2'd2,
        MTR_IMM  = 2'd3
    } memtoreg_e;

    // Codes 5-7 are not enumerated and behave as a full-word load
    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LH  = 3'd1,
        LT_LHU = 3'd2,
        LT_LB  = 3'd3,
        LT_LBU = 3'd4
    } loadtype_e;

    localparam int BYTE_W         = 8;
    localparam int HALF_W         = 16;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

endpackage

// File: rtl/load_formatter.sv
// Extracts and extends the addressed byte/halfword lane of a little-endian load word.
// Purely combinational, zero latency.
// No flow control.
module load_formatter
    import wb_pkg::*;
(
    input  logic [WORD_W-1:0] read_data,
    input  logic [2:0]        load_type,
    input  logic [1:0]        byte_offset,
    output logic [WORD_W-1:0] load_data
);

    logic [BYTE_W-1:0] lane_byte;
    logic [HALF_W-1:0] lane_half;

    always_comb begin
        lane_byte = read_data[BYTE_W-1:0];
        case (byte_offset)
            2'd0:    lane_byte = read_data[BYTE_W-1:0];
            2'd1:    lane_byte = read_data[2*BYTE_W-1:BYTE_W];
            2'd2:    lane_byte = read_data[3*BYTE_W-1:2*BYTE_W];
            default: lane_byte = read_data[4*BYTE_W-1:3*BYTE_W];
        endcase
    end

    // Halfword lane ignores offset[0]; a misaligned halfword still returns the aligned lane
    assign lane_half = byte_offset[1] ? read_data[WORD_W-1:HALF_W] : read_data[HALF_W-1:0];

    always_comb begin
        load_data = read_data;
        case (load_type)
            LT_LH:   load_data = {{(WORD_W-HALF_W){lane_half[HALF_W-1]}}, lane_half};
            LT_LHU:  load_data = {{(WORD_W-HALF_W){1'b0}}, lane_half};
            LT_LB:   load_data = {{(WORD_W-BYTE_W){lane_byte[BYTE_W-1]}}, lane_byte};
            LT_LBU:  load_data = {{(WORD_W-BYTE_W){1'b0}}, lane_byte};
            default: load_data = read_data;
        endcase
    end

endmodule

// File: rtl/write_back_unit.sv
// Write-back pipeline stage: registers M-stage results, selects/format the write data, counts retirements.
// Latency 1 cycle from M inputs to W outputs; result is combinational from W registers.
// Stall holds every W register; flush drops the valid bit; no ready/valid handshake.
module write_back_unit
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                      i_CLK,
    input  logic                      i_RST_n,
    input  logic                      i_StallW,
    input  logic                      i_FlushW,
    input  logic                      i_ValidM,
    input  logic                      i_RegWriteM,
    input  logic [REG_ADDR_WIDTH-1:0] i_WriteRegM,
    input  logic [1:0]                i_MemtoRegM,
    input  logic [2:0]                i_LoadTypeM,
    input  logic [1:0]                i_ByteOffsetM,
    input  logic [DATA_WIDTH-1:0]     i_ALUOutM,
    input  logic [DATA_WIDTH-1:0]     i_ReadDataM,
    input  logic [DATA_WIDTH-1:0]     i_ImmUpperM,
    input  logic [ADDRESS_WIDTH-1:0]  i_PCPlus4M,
    output logic                      o_RegWriteW,
    output logic [REG_ADDR_WIDTH-1:0] o_WriteRegW,
    output logic [DATA_WIDTH-1:0]     o_ResultW,
    output logic                      o_ValidW,
    output logic                      o_MisalignW,
    output logic [COUNT_WIDTH-1:0]    o_RetireCount
);

    if (DATA_WIDTH != WORD_W) begin : g_bad_data_width
        $error("write_back_unit: DATA_WIDTH must be 32");
    end
    if (ADDRESS_WIDTH > DATA_WIDTH) begin : g_bad_addr_width
        $error("write_back_unit: ADDRESS_WIDTH must not exceed DATA_WIDTH");
    end

    logic                      valid_w;
    logic                      regwrite_w;
    logic [REG_ADDR_WIDTH-1:0] writereg_w;
    logic [1:0]                memtoreg_w;
    logic [2:0]                loadtype_w;
    logic [1:0]                offset_w;
    logic [DATA_WIDTH-1:0]     aluout_w;
    logic [DATA_WIDTH-1:0]     readdata_w;
    logic [DATA_WIDTH-1:0]     immupper_w;
    logic [ADDRESS_WIDTH-1:0]  pcplus4_w;
    logic [COUNT_WIDTH-1:0]    retire_cnt;
    logic [DATA_WIDTH-1:0]     load_data;
    logic [DATA_WIDTH-1:0]     result_w;
    logic                      is_half;
    logic                      is_byte;
    logic                      misalign;

    // Flush only touches the valid bit; payload follows the stall like any other cycle
    always_ff @(posedge i_CLK) begin
        if (!i_RST_n) begin
            valid_w    <= 1'b0;
            regwrite_w <= 1'b0;
            writereg_w <= '0;
            memtoreg_w <= '0;
            loadtype_w <= '0;
            offset_w   <= '0;
            aluout_w   <= '0;
            readdata_w <= '0;
            immupper_w <= '0;
            pcplus4_w  <= '0;
        end else begin
            if (i_FlushW) begin
                valid_w <= 1'b0;
            end else if (!i_StallW) begin
                valid_w <= i_ValidM;
            end
            if (!i_StallW) begin
                regwrite_w <= i_RegWriteM;
                writereg_w <= i_WriteRegM;
                memtoreg_w <= i_MemtoRegM;
                loadtype_w <= i_LoadTypeM;
                offset_w   <= i_ByteOffsetM;
                aluout_w   <= i_ALUOutM;
                readdata_w <= i_ReadDataM;
                immupper_w <= i_ImmUpperM;
                pcplus4_w  <= i_PCPlus4M;
            end
        end
    end

    // The instruction sitting in W retires on the edge it leaves, whether or not a flush arrives
    always_ff @(posedge i_CLK) begin
        if (!i_RST_n) begin
            retire_cnt <= '0;
        end else if (valid_w && !i_StallW) begin
            retire_cnt <= retire_cnt + 1'b1;
        end
    end

    load_formatter u_load_formatter (
        .read_data   (readdata_w),
        .load_type   (loadtype_w),
        .byte_offset (offset_w),
        .load_data   (load_data)
    );

    always_comb begin
        result_w = '0;
        case (memtoreg_w)
            MTR_ALU:  result_w = aluout_w;
            MTR_LOAD: result_w = load_data;
            MTR_PC4:  result_w[ADDRESS_WIDTH-1:0] = pcplus4_w;
            default:  result_w = immupper_w;
        endcase
    end

    assign is_half  = (loadtype_w == LT_LH) || (loadtype_w == LT_LHU);
    assign is_byte  = (loadtype_w == LT_LB) || (loadtype_w == LT_LBU);
    assign misalign = (!is_half && !is_byte && (offset_w != 2'd0)) ||
                      (is_half && offset_w[0]);

    assign o_ValidW      = valid_w;
    assign o_RegWriteW   = valid_w && regwrite_w && (writereg_w != '0);
    assign o_WriteRegW   = writereg_w;
    assign o_ResultW     = result_w;
    assign o_MisalignW   = valid_w && (memtoreg_w == MTR_LOAD) && misalign;
    assign o_RetireCount = retire_cnt;

endmodule

// File: tb/tb_write_back_unit.sv
// Self-checking bench for write_back_unit: directed corner cases then randomized traffic vs a reference model.
module tb_write_back_unit;

    localparam int CW = 4;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        validm;
    logic        rwm;
    logic [4:0]  wrm;
    logic [1:0]  mtrm;
    logic [2:0]  ltm;
    logic [1:0]  offm;
    logic [31:0] alum;
    logic [31:0] rdm;
    logic [31:0] immm;
    logic [31:0] pcm;

    logic          regwrite_w;
    logic [4:0]    writereg_w;
    logic [31:0]   result_w;
    logic          valid_w;
    logic          misalign_w;
    logic [CW-1:0] retire_cnt;

    write_back_unit #(
        .DATA_WIDTH     (32),
        .ADDRESS_WIDTH  (32),
        .REG_ADDR_WIDTH (5),
        .COUNT_WIDTH    (CW)
    ) dut (
        .i_CLK         (clk),
        .i_RST_n       (rst_n),
        .i_StallW      (stall),
        .i_FlushW      (flush),
        .i_ValidM      (validm),
        .i_RegWriteM   (rwm),
        .i_WriteRegM   (wrm),
        .i_MemtoRegM   (mtrm),
        .i_LoadTypeM   (ltm),
        .i_ByteOffsetM (offm),
        .i_ALUOutM     (alum),
        .i_ReadDataM   (rdm),
        .i_ImmUpperM   (immm),
        .i_PCPlus4M    (pcm),
        .o_RegWriteW   (regwrite_w),
        .o_WriteRegW   (writereg_w),
        .o_ResultW     (result_w),
        .o_ValidW      (valid_w),
        .o_MisalignW   (misalign_w),
        .o_RetireCount (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instruction record currently held in W, plus a retirement tally
    typedef struct {
        bit        valid;
        bit        rw;
        bit [4:0]  wr;
        bit [1:0]  mtr;
        bit [2:0]  lt;
        bit [1:0]  off;
        bit [31:0] alu;
        bit [31:0] rd;
        bit [31:0] imm;
        bit [31:0] pc;
    } wrec_t;

    wrec_t       m;
    bit          fields_def;
    int unsigned m_cnt;
    int          checks;
    int          errors;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] exp_load(input wrec_t s);
        int unsigned v;
        case (s.lt)
            3'd1, 3'd2: begin
                v = (s.rd >> (16 * (int'(s.off) / 2))) % 65536;
                if (s.lt == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
            end
            3'd3, 3'd4: begin
                v = (s.rd >> (8 * int'(s.off))) % 256;
                if (s.lt == 3'd3 && v >= 128) v = v + 32'hFFFF_FF00;
            end
            default: v = s.rd;
        endcase
        return v;
    endfunction

    function automatic bit [31:0] exp_result(input wrec_t s);
        case (s.mtr)
            2'd0:    return s.alu;
            2'd1:    return exp_load(s);
            2'd2:    return s.pc;
            default: return s.imm;
        endcase
    endfunction

    function automatic bit exp_misalign(input wrec_t s);
        bit word_ld;
        bit half_ld;
        half_ld = (s.lt == 3'd1) || (s.lt == 3'd2);
        word_ld = !half_ld && (s.lt != 3'd3) && (s.lt != 3'd4);
        return s.valid && (s.mtr == 2'd1) &&
               ((word_ld && s.off != 2'd0) || (half_ld && s.off[0]));
    endfunction

    task automatic present(input bit v, input bit rw, input bit [4:0] wr, input bit [1:0] mtr,
                           input bit [2:0] lt, input bit [1:0] off, input bit [31:0] alu,
                           input bit [31:0] rd, input bit [31:0] imm, input bit [31:0] pc);
        validm = v;   rwm  = rw;  wrm  = wr;  mtrm = mtr; ltm = lt;
        offm   = off; alum = alu; rdm  = rd;  immm = imm; pcm = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m = '{default: 0};
            fields_def = 1'b1;
            m_cnt = 0;
        end else begin
            if (m.valid && !stall) m_cnt = (m_cnt + 1) % (1 << CW);
            if (!stall) begin
                m.valid = validm; m.rw = rwm; m.wr = wrm; m.mtr = mtrm; m.lt = ltm;
                m.off = offm; m.alu = alum; m.rd = rdm; m.imm = immm; m.pc = pcm;
                fields_def = 1'b1;
            end
            if (flush) begin
                m.valid = 1'b0;
                fields_def = 1'b0;
            end
        end
        #1;
        check_val("valid", 32'(valid_w), 32'(m.valid));
        check_val("regwrite", 32'(regwrite_w), 32'(m.valid && m.rw && (m.wr != 0)));
        check_val("misalign", 32'(misalign_w), 32'(exp_misalign(m)));
        check_val("retire", 32'(retire_cnt), m_cnt);
        if (fields_def) begin
            check_val("result", result_w, exp_result(m));
            check_val("writereg", 32'(writereg_w), 32'(m.wr));
        end
    endtask

    initial begin
        int unsigned saved_cnt;
        checks = 0;
        errors = 0;
        fields_def = 1'b0;
        m = '{default: 0};
        m_cnt = 0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        present(1, 1, 5'd7, 2'd3, 3'd0, 2'd0, 32'h1, 32'h2, 32'hDEAD_0000, 32'h44);

        // Reset state
        tick(); tick();
        check_val("rst_result", result_w, 32'h0);
        check_val("rst_regwrite", 32'(regwrite_w), 32'h0);
        check_val("rst_misalign", 32'(misalign_w), 32'h0);
        check_val("rst_count", 32'(retire_cnt), 32'h0);
        rst_n = 1'b1;

        // Signed and unsigned byte from the top lane
        present(1, 1, 5'd3, 2'd1, 3'd3, 2'd3, 32'h0, 32'h80FF_1234, 32'h0, 32'h0);
        tick();
        check_val("lb_off3", result_w, 32'hFFFF_FF80);
        present(1, 1, 5'd3, 2'd1, 3'd4, 2'd3, 32'h0, 32'h80FF_1234, 32'h0, 32'h0);
        tick();
        check_val("lbu_off3", result_w, 32'h0000_0080);

        // Misaligned halfword still formats the low lane
        present(1, 1, 5'd4, 2'd1, 3'd1, 2'd1, 32'h0, 32'h1234_ABCD, 32'h0, 32'h0);
        tick();
        check_val("lh_misalign", 32'(misalign_w), 32'h1);
        check_val("lh_result", result_w, 32'hFFFF_ABCD);

        // Writes to x0 are suppressed
        present(1, 1, 5'd0, 2'd0, 3'd0, 2'd0, 32'h5, 32'h0, 32'h0, 32'h0);
        tick();
        check_val("x0_result", result_w, 32'h5);
        check_val("x0_regwrite", 32'(regwrite_w), 32'h0);

        // Stall holds W and the counter; flush under stall drops valid
        present(1, 1, 5'd9, 2'd0, 3'd0, 2'd0, 32'h1234, 32'h0, 32'h0, 32'h0);
        tick();
        saved_cnt = m_cnt;
        stall = 1'b1;
        present(1, 1, 5'd10, 2'd3, 3'd0, 2'd0, 32'h0, 32'h0, 32'hBEEF_0000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("stall_hold", result_w, 32'h1234);
            check_val("stall_count", 32'(retire_cnt), saved_cnt);
        end
        flush = 1'b1;
        tick();
        check_val("flush_valid", 32'(valid_w), 32'h0);
        check_val("flush_count", 32'(retire_cnt), saved_cnt);
        flush = 1'b0; stall = 1'b0;

        // Counter wrap at COUNT_WIDTH = 4
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        present(1, 0, 5'd1, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) tick();
        check_val("count_full", 32'(retire_cnt), 32'd15);
        tick();
        check_val("count_wrap", 32'(retire_cnt), 32'd0);

        // Reset while stalled overrides the stall
        present(1, 1, 5'd6, 2'd2, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h40);
        tick();
        check_val("pc4_result", result_w, 32'h40);
        stall = 1'b1;
        rst_n = 1'b0;
        tick();
        check_val("rst_stall_result", result_w, 32'h0);
        check_val("rst_stall_valid", 32'(valid_w), 32'h0);
        check_val("rst_stall_regwrite", 32'(regwrite_w), 32'h0);
        check_val("rst_stall_writereg", 32'(writereg_w), 32'h0);
        check_val("rst_stall_count", 32'(retire_cnt), 32'h0);
        rst_n = 1'b1; stall = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            rst_n  = ($urandom_range(0, 99) >= 3);
            stall  = ($urandom_range(0, 99) < 25);
            flush  = ($urandom_range(0, 99) < 15);
            validm = ($urandom_range(0, 99) < 80);
            rwm    = 1'($urandom_range(0, 1));
            wrm    = 5'($urandom_range(0, 31));
            mtrm   = 2'($urandom_range(0, 3));
            ltm    = 3'($urandom_range(0, 7));
            offm   = 2'($urandom_range(0, 3));
            alum   = $urandom;
            rdm    = $urandom;
            immm   = $urandom;
            pcm    = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_back_unit.md
WRITE_BACK_UNIT -- requirements
Module: write_back_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath width; SHALL equal 32, else elaboration error.
REQ-002 Parameter ADDRESS_WIDTH, default 32, PC width; SHALL be <= DATA_WIDTH.
REQ-003 Parameter REG_ADDR_WIDTH, default 5, register-file index width.
REQ-004 Parameter COUNT_WIDTH, default 32, retire-counter width.
REQ-005 Clocking: one clock; reset is synchronous and active-low.
REQ-006 i_CLK  in  1  clock; all state updates on its rising edge.
REQ-007 i_RST_n  in  1  synchronous active-low reset.
REQ-008 i_StallW  in  1  hold all W-stage registers.
REQ-009 i_FlushW  in  1  squash the instruction being captured.
REQ-010 i_ValidM  in  1  M-stage instruction valid.
REQ-011 i_RegWriteM  in  1  instruction writes the register file.
REQ-012 i_WriteRegM  in  REG_ADDR_WIDTH  destination register.
REQ-013 i_MemtoRegM  in  2  result select: 0 ALU, 1 load, 2 PC+4, 3 upper immediate.
REQ-014 i_LoadTypeM  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; 5-7 treated as LW.
REQ-015 i_ByteOffsetM  in  2  load address bits [1:0].
REQ-016 i_ALUOutM, i_ReadDataM, i_ImmUpperM  in  DATA_WIDTH  result sources.
REQ-017 i_PCPlus4M  in  ADDRESS_WIDTH  return address.
REQ-018 o_RegWriteW  out  1  register-file write enable.
REQ-019 o_WriteRegW  out  REG_ADDR_WIDTH  register-file write index.
REQ-020 o_ResultW  out  DATA_WIDTH  write-back data.
REQ-021 o_ValidW  out  1  W-stage instruction valid.
REQ-022 o_MisalignW  out  1  misaligned-load flag.
REQ-023 o_RetireCount  out  COUNT_WIDTH  retired-instruction count.

Function
REQ-024 All M inputs SHALL be captured into W registers one cycle after presentation (latency 1); o_ResultW SHALL be combinational from the W registers only.
REQ-025 Capture priority SHALL be reset > flush > stall > normal.
REQ-026 Flush SHALL clear the valid bit regardless of i_StallW; other fields are don't-care.
REQ-027 Stall without flush SHALL hold every W register, including the valid bit.
REQ-028 o_RegWriteW SHALL be valid AND RegWrite AND (WriteReg != 0).
REQ-029 Result select: ALU → ALUOut; load → formatted load; PC+4 → zero-extended PCPlus4; upper immediate → ImmUpper.
REQ-030 Load formatting: LW passes the word; LH/LHU select the halfword at offset[1], sign- or zero-extended; LB/LBU select the byte at offset[1:0], sign- or zero-extended. Little-endian lane order.
REQ-031 o_MisalignW SHALL be high when valid, MemtoReg = 1, and either LW with offset != 0 or LH/LHU with offset[0] = 1; data is still formatted per REQ-030.
REQ-032 o_RetireCount SHALL increment by 1 on every edge where o_ValidW = 1 and i_StallW = 0, and SHALL wrap from all-ones to 0.
REQ-033 When stall and flush are asserted together, the retire count SHALL still follow REQ-032.

Reset
REQ-034 While i_RST_n = 0 at a clock edge: valid, RegWrite, WriteReg, MemtoReg, LoadType, and offset clear to 0; data registers clear to 0; o_RetireCount clears to 0.
REQ-035 After reset and before the first capture, o_ResultW = 0, o_RegWriteW = 0, and o_MisalignW = 0.
REQ-036 Reset asserted mid-stall SHALL override the stall.

Structure
REQ-037 Package wb_pkg SHALL hold the MemtoReg and LoadType encodings and the byte-lane constants.
REQ-038 Load formatting SHALL live in one combinational sub-module, load_formatter.

Verification
REQ-039 LB, offset 3, ReadData 0x80FF_1234, MemtoReg 1 → next cycle ResultW = 0xFFFF_FF80; with LBU → 0x0000_0080.
REQ-040 LH, offset 1, ReadData 0x1234_ABCD → MisalignW = 1, ResultW = 0xFFFF_ABCD.
REQ-041 RegWrite = 1 with WriteReg = 0, ALUOut 0x5 → ResultW = 5 and RegWriteW = 0.
REQ-042 Stall for 3 cycles, then flush with stall held → W holds its values for 3 cycles; valid = 0 after the flush edge; retire count advances by 0 during the stall.
REQ-043 Preload the counter to all-ones via 2^COUNT_WIDTH-1 retirements with COUNT_WIDTH = 4 → 15 retirements, then one more retirement gives 0.
REQ-044 Reset asserted while stalled with MemtoReg 2 and PCPlus4 0x40 → next edge: all outputs 0.
